// File: rtl/jk_ff_cmd_seq.sv
// Command sequencer for a JK flip-flop: queues HOLD/RESET/SET/TOGGLE
// commands, drives j/k for the requested cycles, then checks q.
module jk_ff_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             q_in,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             mismatch
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = CNT_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             r_j;
  logic             r_k;
  logic [CNT_W-1:0] r_ctr;
  logic             r_expq;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_head;
  logic [1:0]       w_hop;
  logic [CNT_W-1:0] w_hlen;
  logic [CNT_W-1:0] w_len_eff;
  logic             w_base;
  logic             w_exp_new;
  logic             w_nj;
  logic             w_nk;
  logic [CNT_W-1:0] w_nctr;
  logic             w_nexp;

  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_push    = cmd_valid & ~w_full;
  assign w_head    = r_mem[r_rptr];
  assign w_hop     = w_head[EW-1:CNT_W];
  assign w_hlen    = w_head[CNT_W-1:0];
  assign w_len_eff = (w_hlen == '0) ? CNT_W'(1) : w_hlen;

  // Leaving CHECK, the next prediction starts from the observed q.
  assign w_base = (r_state == S_CHECK) ? q_in : r_expq;

  always_comb begin
    w_exp_new = w_base;
    unique case (w_hop)
      2'b00: w_exp_new = w_base;
      2'b01: w_exp_new = 1'b0;
      2'b10: w_exp_new = 1'b1;
      2'b11: w_exp_new = w_base ^ w_len_eff[0];
      default: w_exp_new = w_base;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    w_nj     = r_j;
    w_nk     = r_k;
    w_nctr   = r_ctr;
    w_nexp   = r_expq;
    w_pop    = 1'b0;
    unique case (r_state)
      S_IDLE, S_CHECK: begin
        w_nj = 1'b0;
        w_nk = 1'b0;
        if (r_state == S_CHECK) begin
          w_nexp   = q_in;
          w_nstate = S_IDLE;
        end
        if (!w_empty) begin
          w_pop    = 1'b1;
          w_nj     = w_hop[1];
          w_nk     = w_hop[0];
          w_nctr   = w_len_eff;
          w_nexp   = w_exp_new;
          w_nstate = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_nctr = r_ctr - 1'b1;
        if (r_ctr == CNT_W'(1)) begin
          w_nj     = 1'b0;
          w_nk     = 1'b0;
          w_nstate = S_CHECK;
        end
      end
      default: begin
        w_nj     = 1'b0;
        w_nk     = 1'b0;
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_ctr   <= '0;
      r_expq  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_j     <= w_nj;
      r_k     <= w_nk;
      r_ctr   <= w_nctr;
      r_expq  <= w_nexp;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {cmd_op, cmd_len};
  end

  assign cmd_ready = ~w_full;
  assign j         = r_j;
  assign k         = r_k;
  assign done      = (r_state == S_CHECK);
  assign mismatch  = done & (q_in ^ r_expq);
  assign busy      = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: doc/jk_ff_cmd_seq.md
Name: jk_ff_cmd_seq

Overview:
- Command sequencer sitting directly upstream of jk_ff; its j/k outputs wire straight to the flip-flop's j/k inputs.
- Accepts operation commands (HOLD / RESET / SET / TOGGLE, each with a cycle count) over a valid/ready handshake and buffers them in a small FIFO.
- Drives j/k for the requested number of cycles, then checks the flip-flop's q against an internally tracked expected value and reports completion and mismatch.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- CNT_W, 4, width of the per-command cycle count

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept; equals !full
- cmd_op  input  2  00 HOLD (j=0,k=0), 01 RESET (j=0,k=1), 10 SET (j=1,k=0), 11 TOGGLE (j=1,k=1)
- cmd_len  input  CNT_W  number of drive cycles; 0 is treated as 1
- q_in  input  1  q fed back from jk_ff
- j  output  1  registered j to jk_ff
- k  output  1  registered k to jk_ff
- busy  output  1  state != IDLE or FIFO non-empty
- done  output  1  one-cycle pulse per completed command
- mismatch  output  1  one-cycle pulse, coincident with done, when q_in != expected

Behaviour:
- Reset (reset=0, async): j=0, k=0, done=0, mismatch=0, busy=0, FIFO empty (cmd_ready=1), state=IDLE, drive counter=0, exp_q=0.
- Inputs are ignored while reset=0.
- Handshake: a command is stored at a rising edge where cmd_valid & cmd_ready.
  - cmd_ready depends only on FIFO occupancy, never on cmd_valid.
  - No bypass: a command pushed at edge E can be popped at E+1 at the earliest.
- FIFO pointers wrap modulo DEPTH. Push and pop at the same edge leave the count unchanged. Push when full cannot happen because ready is low.
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE: j=k=0. If the FIFO is non-empty at an edge:
    - pop the head entry;
    - register j/k from op;
    - load the counter with max(len,1);
    - compute the new exp_q: HOLD keeps it, RESET sets 0, SET sets 1, TOGGLE sets exp_q ^ (len_eff[0]);
    - go to DRIVE.
  - DRIVE: j/k held. The counter decrements each edge. At the edge where counter==1: j=k=0, go to CHECK. j/k are therefore high for exactly len_eff cycles, i.e. the flip-flop sees len_eff sampling edges.
  - CHECK: j=k=0 for one cycle; done=1; mismatch = (q_in != exp_q).
    - At the exiting edge, exp_q <= q_in (resync, so a single mismatch does not cascade).
    - If the FIFO is non-empty, pop and go directly to DRIVE with the new j/k.
    - Otherwise go to IDLE.
- Latency: accept at edge E0 → j/k asserted from E1 through E(len_eff+1) → CHECK cycle between E(len_eff+1) and E(len_eff+2), with done high in that cycle.
- Back-to-back commands have exactly one CHECK cycle (j=k=0) between them.
- done and mismatch are registered-state decodes: glitch-free, one cycle wide.
- Reset mid-operation: the command in flight and all FIFO contents are discarded; no done is produced for them.

Test Plan:
- Reset: hold reset=0 15 time units, release → j=0, k=0, cmd_ready=1, busy=0, done=0 until a command is sent.
- SET len=1 accepted at E0 → j=1,k=0 only between E1 and E2; done=1 between E2 and E3; q_in=1; mismatch=0; busy returns to 0 after E3.
- TOGGLE len=3 from q=0 → j=k=1 for exactly 3 cycles; q toggles 0→1→0→1; done with exp_q=1, mismatch=0. Then TOGGLE len=2 → q ends 1, mismatch=0.
- Back-pressure (DEPTH=4): push HOLD len=15, then push continuously. The first command pops at E1, four more fill the FIFO, and cmd_ready drops to 0 so the sixth command stalls. cmd_ready returns to 1 the cycle after the first CHECK pops the next entry; all six done pulses arrive in order.
- Mismatch: hold jk_ff in its own reset while sending SET len=2 → q_in stays 0; done=1 and mismatch=1 in the CHECK cycle. Next HOLD len=1 with q=0 → mismatch=0 (exp_q resynced).
- Reset mid-DRIVE: TOGGLE len=10 plus two queued commands; pull reset low after 3 drive cycles → j=k=0 immediately (asynchronously). After release: busy=0, cmd_ready=1, no done pulses for the discarded commands.
